usr_seq_ctrl: RTL
=================

Name: usr_seq_ctrl

Overview:
- Command sequencer for the 8-bit universal shift register (usr).
- Accepts one command per transaction: data word, shift/rotate mode and repeat count. Executes the command by repeatedly loading the usr and stepping it, feeding each result back in. Returns the final word through a valid/ready result port.
- Sits between a requester (bus/CPU glue) and one usr instance. It is the only driver of the usr's load, sh_ro_lt_rt and ip inputs.

Parameters:
- DATA_W, 8, datapath width; must equal the usr width, and only 8 is supported.
- CNT_W, 3, width of the repeat count, giving 0..7 shifts per command.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst_a, input, 1, reset; synchronous, active-high.
- cmd_valid, input, 1, command present.
- cmd_ready, output, 1, controller can accept a command.
- cmd_data, input, DATA_W, initial word.
- cmd_mode, input, 2, operation: 00 shift left, 01 shift right, 10 rotate left, 11 rotate right (usr encoding).
- cmd_count, input, CNT_W, number of operations to apply.
- abort, input, 1, synchronous cancel of the command in flight.
- usr_load, output, 1, drives usr load.
- usr_mode, output, 2, drives usr sh_ro_lt_rt.
- usr_ip, output, DATA_W, drives usr ip.
- usr_op, input, DATA_W, usr op output.
- res_valid, output, 1, result available.
- res_ready, input, 1, consumer accepts result.
- res_data, output, DATA_W, final word.
- busy, output, 1, high in every state except IDLE.

Behaviour:
- Reset (rst_a high at a clock edge, at any time including mid-command):
  - state goes to IDLE; internal word, mode and remaining count clear to 0.
  - res_valid=0, res_data=0, usr_load=0, usr_mode=00, usr_ip=0, busy=0, cmd_ready=1 from the next cycle.
  - The usr has its own reset; the controller does not reset it.
- States: IDLE, LOAD, SHIFT, CAPT, DONE.
- IDLE:
  - cmd_ready=1; usr_load=0, usr_mode=00, usr_ip=0.
  - On cmd_valid&cmd_ready: latch word=cmd_data, mode=cmd_mode, rem=cmd_count.
  - Next state is DONE if cmd_count==0, else LOAD.
- LOAD: usr_load=1, usr_ip=word, usr_mode=mode. Go to SHIFT.
- SHIFT: usr_load=0, usr_mode=mode, usr_ip=word. The usr updates op at the end of this cycle. Go to CAPT.
- CAPT:
  - usr_load=0, usr_mode=mode.
  - word<=usr_op; rem<=rem-1.
  - Go to DONE if rem==1, else LOAD.
- DONE:
  - res_valid=1, res_data=word, held stable until res_ready.
  - On res_valid&res_ready go to IDLE; res_valid drops the next cycle.
- cmd_ready is 0 in all states except IDLE; no command queuing. A cmd_valid held during busy waits.
- Latency: a command accepted at the edge ending cycle t gives res_valid high from cycle t+1+3*N, where N=cmd_count. Throughput is one command per 3N+2 cycles when res_ready=1.
- Arithmetic per step follows usr semantics:
  - shift left/right fill 0;
  - rotates wrap the MSB/LSB.
  - No width growth; the count decrement never underflows because CAPT is not entered with rem==0.
- abort:
  - In LOAD, SHIFT or CAPT: go to IDLE at the next edge with no result. usr_load=0 from the next cycle.
  - In DONE: the result is discarded and the state goes to IDLE.
  - In IDLE: ignored.
  - abort and res_ready both high in DONE resolve as a completed handshake.
- rst_a has priority over abort, and abort has priority over all other transitions.
- cmd_mode and cmd_data changes after acceptance have no effect.

Test Plan:
- Bench setup: usr instance connected to the usr_* ports; usr rst_a tied to the bench reset.
- Command 0x81, mode 00, count 1, res_ready=1 -> res_data=0x02 with res_valid at t+4; cmd_ready returns 1 after the handshake.
- Command 0x81, mode 10, count 3 -> 0x0C at t+10. Command 0xF0, mode 01, count 4 -> 0x0F at t+13. Command 0x01, mode 11, count 7 -> 0x02 at t+22.
- Command 0x5A, count 0 -> res_valid at t+1 with res_data=0x5A; usr_load never asserted.
- Completed command with res_ready held 0 for 5 cycles -> res_valid/res_data stable, cmd_ready=0, a pending cmd_valid not accepted. res_ready=1 -> IDLE; the pending command is accepted the following cycle.
- abort in the 2nd SHIFT of a count-5 command -> IDLE next cycle, no res_valid. The next command 0x03, mode 10, count 2 -> 0x0C, proving no stale state.
- rst_a for 1 cycle mid-command (state CAPT) -> next cycle all outputs at reset values, busy=0. The next command completes correctly.

Source files
------------

// File: rtl/usr_seq_ctrl.sv
// Command sequencer for the 8-bit universal shift register: loads a word, steps
// the usr cmd_count times in the chosen mode, and returns the final word.
module usr_seq_ctrl #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst_a,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [1:0]        cmd_mode,
    input  logic [CNT_W-1:0]  cmd_count,
    input  logic              abort,
    output logic              usr_load,
    output logic [1:0]        usr_mode,
    output logic [DATA_W-1:0] usr_ip,
    input  logic [DATA_W-1:0] usr_op,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_CAPT,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [DATA_W-1:0]   r_word;
    logic [1:0]          r_mode;
    logic [CNT_W-1:0]    r_rem;
    logic                w_accept;

    assign w_accept = (r_state == S_IDLE) && cmd_valid;

    always_ff @(posedge clk) begin
        if (rst_a) begin
            r_state <= S_IDLE;
            r_word  <= '0;
            r_mode  <= '0;
            r_rem   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_word <= cmd_data;
                r_mode <= cmd_mode;
                r_rem  <= cmd_count;
            end else if (r_state == S_CAPT && !abort) begin
                r_word <= usr_op;
                r_rem  <= r_rem - CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (cmd_valid) w_next = (cmd_count == '0) ? S_DONE : S_LOAD;
            S_LOAD:  w_next = abort ? S_IDLE : S_SHIFT;
            S_SHIFT: w_next = abort ? S_IDLE : S_CAPT;
            S_CAPT: begin
                if (abort)
                    w_next = S_IDLE;
                else
                    w_next = (r_rem == CNT_W'(1)) ? S_DONE : S_LOAD;
            end
            // abort in DONE drops the result; with res_ready it is a handshake
            S_DONE:  if (res_ready || abort) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b1;
        usr_load  = 1'b0;
        usr_mode  = '0;
        usr_ip    = '0;
        res_valid = 1'b0;
        res_data  = '0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            S_LOAD: begin
                usr_load = 1'b1;
                usr_mode = r_mode;
                usr_ip   = r_word;
            end
            S_SHIFT, S_CAPT: begin
                usr_mode = r_mode;
                usr_ip   = r_word;
            end
            S_DONE: begin
                res_valid = 1'b1;
                res_data  = r_word;
            end
            default: ;
        endcase
    end

endmodule
